// File: rtl/vtage_pkg.sv
// Shared types and constants for the VTAGE commit-side feedback controller.
// Optional build macro: VTAGE_FB_STATS_EN (adds 32-bit event counters to vtage_fb_ctrl).
// The lane count and confidence width default from `P_NUM_PRED / `P_CONF_THRES_WIDTH.

`ifndef P_NUM_PRED
`define P_NUM_PRED 2
`endif

`ifndef P_CONF_THRES_WIDTH
`define P_CONF_THRES_WIDTH 3
`endif

package vtage_pkg;

    localparam int unsigned CONF_THRES_WIDTH = `P_CONF_THRES_WIDTH;
    localparam logic [CONF_THRES_WIDTH-1:0] CONF_MAX = '1;
    localparam logic [1:0] USE_MAX = 2'd3;
    localparam int unsigned STAT_W = 32;

    typedef enum logic [2:0] {
        FB_NONE,
        FB_HIT_OK,
        FB_HIT_BAD,
        FB_MISS_ALLOC,
        FB_MISS_AGE
    } fb_case_e;

    // Saturating add for the event counters; they stick at all-ones.
    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                  input logic [STAT_W-1:0] b);
        logic [STAT_W:0] s;
        s = (STAT_W+1)'(a) + (STAT_W+1)'(b);
        return s[STAT_W] ? '1 : s[STAT_W-1:0];
    endfunction

endpackage

// File: rtl/vtage_fb_lane.sv
// One commit lane: classifies the outcome and produces the combinational
// feedback pulses that the top level registers.

module vtage_fb_lane
    import vtage_pkg::*;
#(
    parameter int unsigned P_CONF_THRES_WIDTH = `P_CONF_THRES_WIDTH,
    parameter int unsigned P_HASH_LENGTH      = 15
) (
    input  logic                          valid,
    input  logic                          tag_match,
    input  logic [P_HASH_LENGTH-1:0]      pred_value,
    input  logic [P_HASH_LENGTH-1:0]      actual_value,
    input  logic [P_CONF_THRES_WIDTH-1:0] conf,
    input  logic [1:0]                    useful,
    output logic                          incr_conf_c,
    output logic                          rst_conf_c,
    output logic                          incr_use_c,
    output logic                          decr_use_c,
    output logic                          load_tag_c,
    output logic                          load_value_c
`ifdef VTAGE_FB_STATS_EN
    ,
    output fb_case_e                      fb_case_c
`endif
);

    localparam logic [P_CONF_THRES_WIDTH-1:0] LANE_CONF_MAX = '1;

    fb_case_e fb_case;
    logic     correct;

    // Classify the commit outcome into one of the feedback cases.
    always_comb begin
        fb_case = FB_NONE;
        correct = (pred_value == actual_value);
        if (valid) begin
            if (tag_match) begin
                fb_case = correct ? FB_HIT_OK : FB_HIT_BAD;
            end else begin
                fb_case = (useful == 2'd0) ? FB_MISS_ALLOC : FB_MISS_AGE;
            end
        end
    end

    // Translate the case into entry update pulses; counters saturate, never wrap.
    always_comb begin
        incr_conf_c  = 1'b0;
        rst_conf_c   = 1'b0;
        incr_use_c   = 1'b0;
        decr_use_c   = 1'b0;
        load_tag_c   = 1'b0;
        load_value_c = 1'b0;
        case (fb_case)
            FB_HIT_OK: begin
                incr_conf_c = (conf != LANE_CONF_MAX);
                incr_use_c  = (useful != USE_MAX);
            end
            FB_HIT_BAD: begin
                rst_conf_c   = 1'b1;
                decr_use_c   = (useful != 2'd0);
                load_value_c = (conf == '0);
            end
            FB_MISS_ALLOC: begin
                load_tag_c   = 1'b1;
                load_value_c = 1'b1;
                rst_conf_c   = 1'b1;
            end
            FB_MISS_AGE: begin
                decr_use_c = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef VTAGE_FB_STATS_EN
    assign fb_case_c = fb_case;
`endif

endmodule

// File: rtl/vtage_fb_ctrl.sv
// Commit-side feedback controller for the VTAGE predictor entry: registers
// per-lane feedback pulses and load data, and runs the usefulness decay counter.
// Optional build macro: VTAGE_FB_STATS_EN adds stat_hit_ok_o / stat_hit_bad_o / stat_alloc_o.

module vtage_fb_ctrl
    import vtage_pkg::*;
#(
    parameter int unsigned P_NUM_PRED         = `P_NUM_PRED,
    parameter int unsigned P_CONF_THRES_WIDTH = `P_CONF_THRES_WIDTH,
    parameter int unsigned P_HASH_LENGTH      = 15,
    parameter int unsigned P_DECAY_LOG        = 8
) (
    input  logic                                           clk_i,
    input  logic                                           rst_n_i,
    input  logic [P_NUM_PRED-1:0]                          cm_valid_i,
    input  logic [P_NUM_PRED-1:0]                          cm_tag_match_i,
    input  logic [P_NUM_PRED-1:0][P_HASH_LENGTH-1:0]       cm_tag_i,
    input  logic [P_NUM_PRED-1:0][P_HASH_LENGTH-1:0]       cm_pred_value_i,
    input  logic [P_NUM_PRED-1:0][P_HASH_LENGTH-1:0]       cm_actual_value_i,
    input  logic [P_NUM_PRED-1:0][P_CONF_THRES_WIDTH-1:0]  cm_conf_i,
    input  logic [P_NUM_PRED-1:0][1:0]                     cm_useful_i,
    output logic [P_NUM_PRED-1:0]                          fb_incr_conf_o,
    output logic [P_NUM_PRED-1:0]                          fb_rst_conf_o,
    output logic [P_NUM_PRED-1:0]                          fb_incr_use_o,
    output logic [P_NUM_PRED-1:0]                          fb_decr_use_o,
    output logic [P_NUM_PRED-1:0]                          fb_load_tag_o,
    output logic [P_NUM_PRED-1:0]                          fb_load_value_o,
    output logic [P_NUM_PRED-1:0][P_HASH_LENGTH-1:0]       fb_tag_o,
    output logic [P_NUM_PRED-1:0][P_HASH_LENGTH-1:0]       fb_value_o,
`ifdef VTAGE_FB_STATS_EN
    output logic [STAT_W-1:0]                              stat_hit_ok_o,
    output logic [STAT_W-1:0]                              stat_hit_bad_o,
    output logic [STAT_W-1:0]                              stat_alloc_o,
`endif
    output logic                                           decay_pulse_o
);

    localparam int unsigned CNT_W = P_DECAY_LOG + 1;
    localparam int unsigned POP_W = $clog2(P_NUM_PRED + 1);
    localparam int unsigned SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam logic [SUM_W-1:0] DECAY_PERIOD = SUM_W'(1) << P_DECAY_LOG;
    localparam logic [SUM_W-1:0] DECAY_MASK   = DECAY_PERIOD - SUM_W'(1);

    logic [P_NUM_PRED-1:0] lane_incr_conf;
    logic [P_NUM_PRED-1:0] lane_rst_conf;
    logic [P_NUM_PRED-1:0] lane_incr_use;
    logic [P_NUM_PRED-1:0] lane_decr_use;
    logic [P_NUM_PRED-1:0] lane_load_tag;
    logic [P_NUM_PRED-1:0] lane_load_value;

    logic [CNT_W-1:0] decay_cnt;
    logic [CNT_W-1:0] decay_cnt_nxt_c;
    logic [POP_W-1:0] commit_cnt_c;
    logic [SUM_W-1:0] decay_sum_c;
    logic             decay_wrap_c;

`ifdef VTAGE_FB_STATS_EN
    fb_case_e [P_NUM_PRED-1:0] lane_case;
`endif

    // Per-lane classification and pulse generation.
    for (genvar i = 0; i < P_NUM_PRED; i++) begin : g_lane
        vtage_fb_lane #(
            .P_CONF_THRES_WIDTH (P_CONF_THRES_WIDTH),
            .P_HASH_LENGTH      (P_HASH_LENGTH)
        ) u_lane (
            .valid        (cm_valid_i[i]),
            .tag_match    (cm_tag_match_i[i]),
            .pred_value   (cm_pred_value_i[i]),
            .actual_value (cm_actual_value_i[i]),
            .conf         (cm_conf_i[i]),
            .useful       (cm_useful_i[i]),
            .incr_conf_c  (lane_incr_conf[i]),
            .rst_conf_c   (lane_rst_conf[i]),
            .incr_use_c   (lane_incr_use[i]),
            .decr_use_c   (lane_decr_use[i]),
            .load_tag_c   (lane_load_tag[i]),
`ifdef VTAGE_FB_STATS_EN
            .fb_case_c    (lane_case[i]),
`endif
            .load_value_c (lane_load_value[i])
        );
    end

    // Decay accumulation: add this cycle's commits, wrap modulo the period keeping the remainder.
    always_comb begin
        commit_cnt_c = '0;
        for (int i = 0; i < P_NUM_PRED; i++) begin
            if (cm_valid_i[i]) begin
                commit_cnt_c = commit_cnt_c + POP_W'(1);
            end
        end
        decay_sum_c     = SUM_W'(decay_cnt) + SUM_W'(commit_cnt_c);
        decay_wrap_c    = (decay_sum_c >= DECAY_PERIOD);
        decay_cnt_nxt_c = CNT_W'(decay_sum_c & DECAY_MASK);
    end

    // Decay counter and decay pulse register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            decay_cnt     <= '0;
            decay_pulse_o <= 1'b0;
        end else begin
            decay_cnt     <= decay_cnt_nxt_c;
            decay_pulse_o <= decay_wrap_c;
        end
    end

    // Feedback pulse registers; a decay cycle forces every lane to decrement usefulness.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fb_incr_conf_o  <= '0;
            fb_rst_conf_o   <= '0;
            fb_incr_use_o   <= '0;
            fb_decr_use_o   <= '0;
            fb_load_tag_o   <= '0;
            fb_load_value_o <= '0;
        end else begin
            fb_incr_conf_o  <= lane_incr_conf;
            fb_rst_conf_o   <= lane_rst_conf;
            fb_incr_use_o   <= decay_wrap_c ? '0 : lane_incr_use;
            fb_decr_use_o   <= decay_wrap_c ? '1 : lane_decr_use;
            fb_load_tag_o   <= lane_load_tag;
            fb_load_value_o <= lane_load_value;
        end
    end

    // Load data registers; they hold their value unless the lane loads.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fb_tag_o   <= '0;
            fb_value_o <= '0;
        end else begin
            for (int i = 0; i < P_NUM_PRED; i++) begin
                if (lane_load_tag[i]) begin
                    fb_tag_o[i] <= cm_tag_i[i];
                end
                if (lane_load_value[i]) begin
                    fb_value_o[i] <= cm_actual_value_i[i];
                end
            end
        end
    end

`ifdef VTAGE_FB_STATS_EN
    logic [POP_W-1:0] n_hit_ok_c;
    logic [POP_W-1:0] n_hit_bad_c;
    logic [POP_W-1:0] n_alloc_c;

    // Count this cycle's events across lanes.
    always_comb begin
        n_hit_ok_c  = '0;
        n_hit_bad_c = '0;
        n_alloc_c   = '0;
        for (int i = 0; i < P_NUM_PRED; i++) begin
            if (lane_case[i] == FB_HIT_OK) begin
                n_hit_ok_c = n_hit_ok_c + POP_W'(1);
            end
            if (lane_case[i] == FB_HIT_BAD) begin
                n_hit_bad_c = n_hit_bad_c + POP_W'(1);
            end
            if (lane_case[i] == FB_MISS_ALLOC) begin
                n_alloc_c = n_alloc_c + POP_W'(1);
            end
        end
    end

    // Free-running saturating event counters.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stat_hit_ok_o  <= '0;
            stat_hit_bad_o <= '0;
            stat_alloc_o   <= '0;
        end else begin
            stat_hit_ok_o  <= sat_add(stat_hit_ok_o, STAT_W'(n_hit_ok_c));
            stat_hit_bad_o <= sat_add(stat_hit_bad_o, STAT_W'(n_hit_bad_c));
            stat_alloc_o   <= sat_add(stat_alloc_o, STAT_W'(n_alloc_c));
        end
    end
`endif

endmodule

// File: tb/tb_vtage_fb_ctrl.sv
// Directed self-checking bench for vtage_fb_ctrl (2 lanes, decay period 4).

module tb_vtage_fb_ctrl;
    import vtage_pkg::*;

    localparam int unsigned N  = 2;
    localparam int unsigned CW = 3;
    localparam int unsigned HL = 15;
    localparam int unsigned DL = 2;
    localparam int          PERIOD = 1 << DL;

    logic                       clk_i = 1'b0;
    logic                       rst_n_i = 1'b1;
    logic [N-1:0]               cm_valid_i;
    logic [N-1:0]               cm_tag_match_i;
    logic [N-1:0][HL-1:0]       cm_tag_i;
    logic [N-1:0][HL-1:0]       cm_pred_value_i;
    logic [N-1:0][HL-1:0]       cm_actual_value_i;
    logic [N-1:0][CW-1:0]       cm_conf_i;
    logic [N-1:0][1:0]          cm_useful_i;
    logic [N-1:0]               fb_incr_conf_o;
    logic [N-1:0]               fb_rst_conf_o;
    logic [N-1:0]               fb_incr_use_o;
    logic [N-1:0]               fb_decr_use_o;
    logic [N-1:0]               fb_load_tag_o;
    logic [N-1:0]               fb_load_value_o;
    logic [N-1:0][HL-1:0]       fb_tag_o;
    logic [N-1:0][HL-1:0]       fb_value_o;
    logic                       decay_pulse_o;
`ifdef VTAGE_FB_STATS_EN
    logic [31:0]                stat_hit_ok_o;
    logic [31:0]                stat_hit_bad_o;
    logic [31:0]                stat_alloc_o;
`endif

    vtage_fb_ctrl #(
        .P_NUM_PRED         (N),
        .P_CONF_THRES_WIDTH (CW),
        .P_HASH_LENGTH      (HL),
        .P_DECAY_LOG        (DL)
    ) dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .cm_valid_i        (cm_valid_i),
        .cm_tag_match_i    (cm_tag_match_i),
        .cm_tag_i          (cm_tag_i),
        .cm_pred_value_i   (cm_pred_value_i),
        .cm_actual_value_i (cm_actual_value_i),
        .cm_conf_i         (cm_conf_i),
        .cm_useful_i       (cm_useful_i),
        .fb_incr_conf_o    (fb_incr_conf_o),
        .fb_rst_conf_o     (fb_rst_conf_o),
        .fb_incr_use_o     (fb_incr_use_o),
        .fb_decr_use_o     (fb_decr_use_o),
        .fb_load_tag_o     (fb_load_tag_o),
        .fb_load_value_o   (fb_load_value_o),
        .fb_tag_o          (fb_tag_o),
        .fb_value_o        (fb_value_o),
`ifdef VTAGE_FB_STATS_EN
        .stat_hit_ok_o     (stat_hit_ok_o),
        .stat_hit_bad_o    (stat_hit_bad_o),
        .stat_alloc_o      (stat_alloc_o),
`endif
        .decay_pulse_o     (decay_pulse_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [N-1:0]         ic;
        logic [N-1:0]         rc;
        logic [N-1:0]         iu;
        logic [N-1:0]         du;
        logic [N-1:0]         lt;
        logic [N-1:0]         lv;
        logic [N-1:0][HL-1:0] tag;
        logic [N-1:0][HL-1:0] val;
        logic                 dp;
        int                   cnt;
    } exp_t;

    exp_t                 sb[$];
    int                   n_cmp = 0;
    int                   n_bad = 0;
    int                   acc   = 0;
    logic [N-1:0][HL-1:0] exp_tag = '0;
    logic [N-1:0][HL-1:0] exp_val = '0;

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".incr_conf"},  64'(fb_incr_conf_o),  64'd0);
        chk({nm, ".rst_conf"},   64'(fb_rst_conf_o),   64'd0);
        chk({nm, ".incr_use"},   64'(fb_incr_use_o),   64'd0);
        chk({nm, ".decr_use"},   64'(fb_decr_use_o),   64'd0);
        chk({nm, ".load_tag"},   64'(fb_load_tag_o),   64'd0);
        chk({nm, ".load_value"}, 64'(fb_load_value_o), 64'd0);
        chk({nm, ".tag"},        64'(fb_tag_o),        64'd0);
        chk({nm, ".value"},      64'(fb_value_o),      64'd0);
        chk({nm, ".decay"},      64'(decay_pulse_o),   64'd0);
    endtask

    // Drive one cycle of commits, push the expected outcome, then check after the edge.
    task automatic step(input string nm, input logic [N-1:0] v, input logic [N-1:0] m,
                        input logic [HL-1:0] tg, input logic [HL-1:0] pv, input logic [HL-1:0] av,
                        input logic [CW-1:0] cf, input logic [1:0] us,
                        input logic [N-1:0] ic, input logic [N-1:0] rc, input logic [N-1:0] iu,
                        input logic [N-1:0] du, input logic [N-1:0] lt, input logic [N-1:0] lv);
        exp_t e;
        logic dec;
        cm_valid_i     = v;
        cm_tag_match_i = m;
        for (int i = 0; i < N; i++) begin
            cm_tag_i[i]          = tg;
            cm_pred_value_i[i]   = pv;
            cm_actual_value_i[i] = av;
            cm_conf_i[i]         = cf;
            cm_useful_i[i]       = us;
        end
        acc = acc + $countones(v);
        dec = (acc >= PERIOD);
        if (dec) acc = acc - PERIOD;
        for (int i = 0; i < N; i++) begin
            if (lt[i]) exp_tag[i] = tg;
            if (lv[i]) exp_val[i] = av;
        end
        e.ic  = ic;
        e.rc  = rc;
        e.iu  = dec ? '0 : iu;
        e.du  = dec ? '1 : du;
        e.lt  = lt;
        e.lv  = lv;
        e.tag = exp_tag;
        e.val = exp_val;
        e.dp  = dec;
        e.cnt = acc;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        e = sb.pop_front();
        chk({nm, ".incr_conf"},  64'(fb_incr_conf_o),  64'(e.ic));
        chk({nm, ".rst_conf"},   64'(fb_rst_conf_o),   64'(e.rc));
        chk({nm, ".incr_use"},   64'(fb_incr_use_o),   64'(e.iu));
        chk({nm, ".decr_use"},   64'(fb_decr_use_o),   64'(e.du));
        chk({nm, ".load_tag"},   64'(fb_load_tag_o),   64'(e.lt));
        chk({nm, ".load_value"}, 64'(fb_load_value_o), 64'(e.lv));
        chk({nm, ".tag"},        64'(fb_tag_o),        64'(e.tag));
        chk({nm, ".value"},      64'(fb_value_o),      64'(e.val));
        chk({nm, ".decay"},      64'(decay_pulse_o),   64'(e.dp));
        chk({nm, ".decay_cnt"},  64'(dut.decay_cnt),   64'(e.cnt));
        chk({nm, ".excl_conf"},  64'(fb_incr_conf_o & fb_rst_conf_o), 64'd0);
        chk({nm, ".excl_use"},   64'(fb_incr_use_o & fb_decr_use_o),  64'd0);
    endtask

    // Assert reset asynchronously, check the outputs clear at once, release on a falling edge.
    task automatic do_reset(input string nm);
        rst_n_i = 1'b0;
        #1;
        chk_all_zero(nm);
        cm_valid_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        acc     = 0;
        exp_tag = '0;
        exp_val = '0;
        sb.delete();
    endtask

    initial begin
        cm_valid_i        = '0;
        cm_tag_match_i    = '0;
        cm_tag_i          = '0;
        cm_pred_value_i   = '0;
        cm_actual_value_i = '0;
        cm_conf_i         = '0;
        cm_useful_i       = '0;
        #1;
        do_reset("por");

        // Single-lane case coverage on lane 0.
        step("hit_ok_sat", 2'b01, 2'b11, 15'h0, 15'h1234, 15'h1234, CONF_MAX, 2'd3,
             2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        step("hit_ok",     2'b01, 2'b11, 15'h0, 15'h1234, 15'h1234, 3'd2, 2'd1,
             2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
        step("hit_bad_c0", 2'b01, 2'b11, 15'h0, 15'h0010, 15'h0020, 3'd0, 2'd2,
             2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01);
        step("hit_bad_c3", 2'b01, 2'b11, 15'h0, 15'h0010, 15'h0030, 3'd3, 2'd0,
             2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        step("alloc",      2'b01, 2'b00, 15'h7ABC, 15'h0001, 15'h0042, 3'd5, 2'd0,
             2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01);
        step("age",        2'b01, 2'b00, 15'h1111, 15'h0001, 15'h0099, 3'd5, 2'd1,
             2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        step("invalid",    2'b00, 2'b11, 15'h5555, 15'h0000, 15'h6666, 3'd7, 2'd0,
             2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        step("idle",       2'b00, 2'b00, 15'h0, 15'h0, 15'h0, 3'd0, 2'd0,
             2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

        // Lane 1 alone, then both lanes allocating across the decay wrap (remainder 1).
        step("lane1_bad",  2'b10, 2'b10, 15'h0, 15'h0001, 15'h0002, 3'd0, 2'd1,
             2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10);
        step("alloc_wrap", 2'b11, 2'b00, 15'h2468, 15'h0001, 15'h0777, 3'd1, 2'd0,
             2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11);
        step("rem_hit0",   2'b01, 2'b01, 15'h0, 15'h0100, 15'h0100, 3'd1, 2'd2,
             2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
        step("rem_hit2",   2'b11, 2'b11, 15'h0, 15'h0100, 15'h0100, 3'd1, 2'd2,
             2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
        step("post_decay", 2'b00, 2'b00, 15'h0, 15'h0, 15'h0, 3'd0, 2'd0,
             2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

        // Reset in the middle of live traffic.
        step("pre_rst",    2'b11, 2'b11, 15'h0, 15'h0005, 15'h0005, 3'd2, 2'd1,
             2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
        #2;
        do_reset("mid_rst");
        step("after_rst",  2'b00, 2'b00, 15'h0, 15'h0, 15'h0, 3'd0, 2'd0,
             2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

        // Decay: both lanes HIT_OK with useful 0; pulse after every 4 commits.
        step("decay_c1",   2'b11, 2'b11, 15'h0, 15'h0042, 15'h0042, 3'd1, 2'd0,
             2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
        step("decay_c2",   2'b11, 2'b11, 15'h0, 15'h0042, 15'h0042, 3'd1, 2'd0,
             2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
        step("decay_c3",   2'b11, 2'b11, 15'h0, 15'h0042, 15'h0042, 3'd1, 2'd0,
             2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
        step("decay_c4",   2'b11, 2'b11, 15'h0, 15'h0042, 15'h0042, 3'd1, 2'd0,
             2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
        step("decay_idle", 2'b00, 2'b00, 15'h0, 15'h0, 15'h0, 3'd0, 2'd0,
             2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
